// File: rtl/scs8hd_wake_pkg.sv
// Shared definitions for the scs8hd wake-filter family.
// Holds the FSM state encodings and the default debounce depth.
package scs8hd_wake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RISE_CHK = 2'b01,
    ST_ON       = 2'b11,
    ST_FALL_CHK = 2'b10
  } wake_state_e;

  localparam int WAKE_DEB_CYCLES = 4;

endpackage : scs8hd_wake_pkg

// File: rtl/scs8hd_sync_n.sv
// N-stage flop synchronizer for a single asynchronous level.
// The input feeds only the first flop; Q is the last stage.
module scs8hd_sync_n #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RESETB,
  input  logic D,
  output logic Q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // shift the raw level one stage deeper every clock
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], D};
  end

  // synchronizer chain register
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign Q = sync_q[SYNC_STAGES-1];

endmodule : scs8hd_sync_n

// File: rtl/scs8hd_wake_filter.sv
// Wake-request debouncer: synchronizes A, qualifies each level change for
// DEB_CYCLES stable samples, and drives registered level X, rise pulse P and BUSY.
module scs8hd_wake_filter
  import scs8hd_wake_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = WAKE_DEB_CYCLES,
  parameter int CNT_W       = 4
) (
`ifdef SC_USE_PG_PIN
  input  logic vpwr,
  input  logic vgnd,
  input  logic vpb,
  input  logic vnb,
`endif
  input  logic CLK,
  input  logic RESETB,
  input  logic A,
  input  logic EN,
  input  logic CLR,
  output logic X,
  output logic P,
  output logic BUSY
);

`ifndef SC_USE_PG_PIN
  supply1 vpwr;
  supply0 vgnd;
  supply1 vpb;
  supply0 vnb;
`endif

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic        pg_ok_s;
  logic        rst_n_s;
  logic        sync_s;

  wake_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             p_q, p_d;
  logic             busy_q, busy_d;

  // an unpowered cell is held in reset; with tied supplies this folds to RESETB
  assign pg_ok_s = vpwr & vpb & ~vgnd & ~vnb;
  assign rst_n_s = RESETB & pg_ok_s;

  scs8hd_sync_n #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK    (CLK),
    .RESETB (rst_n_s),
    .D      (A),
    .Q      (sync_s)
  );

  // next-state, counter and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    p_d     = 1'b0;
    if (CLR || !EN) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
      x_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sync_s) begin
            state_d = ST_RISE_CHK;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end
          x_d = 1'b0;
        end
        ST_RISE_CHK: begin
          if (!sync_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            x_d     = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_ON;
            cnt_d   = CNT_ZERO;
            x_d     = 1'b1;
            p_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_ON: begin
          if (!sync_s) begin
            state_d = ST_FALL_CHK;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = ST_ON;
            cnt_d   = CNT_ZERO;
          end
          x_d = 1'b1;
        end
        ST_FALL_CHK: begin
          // a bounce back high returns to ON without a new pulse
          if (sync_s) begin
            state_d = ST_ON;
            cnt_d   = CNT_ZERO;
            x_d     = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
            x_d     = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
          x_d     = 1'b0;
        end
      endcase
    end
    busy_d = (state_d == ST_RISE_CHK) || (state_d == ST_FALL_CHK);
  end

  // state, counter and output registers
  always_ff @(posedge CLK or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      x_q     <= 1'b0;
      p_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
    end
  end

  assign X    = x_q;
  assign P    = p_q;
  assign BUSY = busy_q;

endmodule : scs8hd_wake_filter

// File: tb/tb_scs8hd_wake_filter.sv
// Directed self-checking bench for scs8hd_wake_filter at default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_scs8hd_wake_filter;

  logic CLK;
  logic RESETB;
  logic A;
  logic EN;
  logic CLR;
  logic X;
  logic P;
  logic BUSY;

  int total;
  int bad;

  scs8hd_wake_filter dut (
    .CLK    (CLK),
    .RESETB (RESETB),
    .A      (A),
    .EN     (EN),
    .CLR    (CLR),
    .X      (X),
    .P      (P),
    .BUSY   (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    RESETB = 1'b0;
    A      = 1'b1;
    EN     = 1'b1;
    CLR    = 1'b0;

    // reset with A high: outputs clear before any clock edge
    #2;
    chk("rst_x", X, 4'h0);
    chk("rst_p", P, 4'h0);
    chk("rst_busy", BUSY, 4'h0);
    step();
    chk("rst_state", {2'b00, dut.state_q}, 4'h0);
    RESETB = 1'b1;

    // first qualification: BUSY from edge 3, X/P at edge 6
    step();
    step();
    chk("up_busy_e2", BUSY, 4'h0);
    step();
    chk("up_busy_e3", BUSY, 4'h1);
    chk("up_cnt_e3", dut.cnt_q, 4'h1);
    step();
    step();
    chk("up_x_e5", X, 4'h0);
    chk("up_p_e5", P, 4'h0);
    step();
    chk("up_x_e6", X, 4'h1);
    chk("up_p_e6", P, 4'h1);
    chk("up_busy_e6", BUSY, 4'h0);
    step();
    chk("up_p_e7", P, 4'h0);
    chk("up_x_e7", X, 4'h1);

    // fall: A low and held, X drops at edge 6, never a pulse
    A = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("fall_p", P, 4'h0);
      if (i == 3) chk("fall_busy_e3", BUSY, 4'h1);
      if (i == 5) chk("fall_x_e5", X, 4'h1);
    end
    chk("fall_x_e6", X, 4'h0);
    chk("fall_busy_e6", BUSY, 4'h0);

    // glitch: three high samples are one short of qualifying
    A = 1'b1;
    step();
    step();
    step();
    A = 1'b0;
    chk("gl_busy_e3", BUSY, 4'h1);
    step();
    step();
    chk("gl_busy_e5", BUSY, 4'h1);
    chk("gl_cnt_e5", dut.cnt_q, 4'h3);
    step();
    chk("gl_busy_e6", BUSY, 4'h0);
    chk("gl_x_e6", X, 4'h0);
    chk("gl_p_e6", P, 4'h0);
    chk("gl_state_e6", {2'b00, dut.state_q}, 4'h0);
    chk("gl_cnt_e6", dut.cnt_q, 4'h0);

    // back to ON for the bounce test
    A = 1'b1;
    for (int i = 1; i <= 6; i++) step();
    chk("on_x", X, 4'h1);
    chk("on_p", P, 4'h1);
    step();

    // bounce: two low samples then high, X holds and no pulse
    A = 1'b0;
    step();
    step();
    A = 1'b1;
    for (int i = 3; i <= 7; i++) begin
      step();
      chk("bn_x", X, 4'h1);
      chk("bn_p", P, 4'h0);
      if (i == 3 || i == 4) chk("bn_busy_hi", BUSY, 4'h1);
      if (i == 5) chk("bn_busy_lo", BUSY, 4'h0);
    end
    chk("bn_state", {2'b00, dut.state_q}, 4'h3);

    // enable low in ON drops X on the next edge
    EN = 1'b0;
    step();
    chk("en_x", X, 4'h0);
    chk("en_state", {2'b00, dut.state_q}, 4'h0);
    EN = 1'b1;
    step();
    chk("en_busy", BUSY, 4'h1);
    chk("en_cnt", dut.cnt_q, 4'h1);

    // clear wins over enable during RISE_CHK
    CLR = 1'b1;
    step();
    chk("clr_state", {2'b00, dut.state_q}, 4'h0);
    chk("clr_busy", BUSY, 4'h0);
    chk("clr_cnt", dut.cnt_q, 4'h0);
    CLR = 1'b0;

    // re-qualify: new pulse on the 4th qualifying edge
    step();
    step();
    step();
    chk("re_x_q3", X, 4'h0);
    chk("re_cnt_q3", dut.cnt_q, 4'h3);
    step();
    chk("re_x_q4", X, 4'h1);
    chk("re_p_q4", P, 4'h1);
    step();
    chk("re_p_q5", P, 4'h0);

    // async reset in RISE_CHK with cnt=2
    EN = 1'b0;
    step();
    EN = 1'b1;
    step();
    step();
    chk("ar_cnt_pre", dut.cnt_q, 4'h2);
    chk("ar_busy_pre", BUSY, 4'h1);
    #2;
    RESETB = 1'b0;
    #1;
    chk("ar_x", X, 4'h0);
    chk("ar_busy", BUSY, 4'h0);
    chk("ar_cnt", dut.cnt_q, 4'h0);
    chk("ar_state", {2'b00, dut.state_q}, 4'h0);
    step();
    RESETB = 1'b1;

    // full latency after reset release
    for (int i = 1; i <= 5; i++) step();
    chk("ar_rel_x_e5", X, 4'h0);
    step();
    chk("ar_rel_x_e6", X, 4'h1);
    chk("ar_rel_p_e6", P, 4'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_scs8hd_wake_filter
